cache_control: RTL and testbench

- Control FSM for the 2-way, 8-set, 128-bit-line write-back cache. It sits between the CPU memory port and the cache datapath.
- It consumes hit, valid, dirty and LRU status from the datapath and drives every array write enable, mux select and physical-memory strobe.
- It returns mem_resp to the CPU and keeps saturating hit and miss counters for performance reporting.

---
 rtl/cache_control_if.sv | 64 ++++++
 rtl/cache_control.sv | 166 ++++++++++++++++
 tb/tb_cache_control.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_control_if.sv
// Signal bundle between the cache control FSM and the CPU port, cache datapath and physical memory.
interface cache_control_if #(
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 mem_read;
    logic                 mem_write;
    logic [2:0]           mem_offset;
    logic [1:0]           mem_byte_enable;
    logic                 mem_resp;

    logic                 hit0;
    logic                 hit1;
    logic                 valid0_out;
    logic                 valid1_out;
    logic                 dirty0_out;
    logic                 dirty1_out;
    logic                 LRU_out;

    logic                 pmem_resp;
    logic                 pmem_read;
    logic                 pmem_write;

    logic                 data0_writeline;
    logic                 data1_writeline;
    logic                 tag0_write;
    logic                 tag1_write;
    logic                 valid0_write;
    logic                 valid1_write;
    logic                 dirty0_write;
    logic                 dirty1_write;
    logic                 valid_in;
    logic                 dirty_in;
    logic                 updateLRU;
    logic                 wb_sel;
    logic [1:0]           adrmux_sel;
    logic [15:0]          offset_sel;

    logic [CNT_WIDTH-1:0] hit_count;
    logic [CNT_WIDTH-1:0] miss_count;

    // Environment side: CPU, datapath and physical memory.
    modport master (
        output mem_read, mem_write, mem_offset, mem_byte_enable,
        output hit0, hit1, valid0_out, valid1_out, dirty0_out, dirty1_out, LRU_out,
        output pmem_resp,
        input  mem_resp, pmem_read, pmem_write,
        input  data0_writeline, data1_writeline, tag0_write, tag1_write,
        input  valid0_write, valid1_write, dirty0_write, dirty1_write,
        input  valid_in, dirty_in, updateLRU, wb_sel, adrmux_sel, offset_sel,
        input  hit_count, miss_count
    );

    // Controller side.
    modport slave (
        input  mem_read, mem_write, mem_offset, mem_byte_enable,
        input  hit0, hit1, valid0_out, valid1_out, dirty0_out, dirty1_out, LRU_out,
        input  pmem_resp,
        output mem_resp, pmem_read, pmem_write,
        output data0_writeline, data1_writeline, tag0_write, tag1_write,
        output valid0_write, valid1_write, dirty0_write, dirty1_write,
        output valid_in, dirty_in, updateLRU, wb_sel, adrmux_sel, offset_sel,
        output hit_count, miss_count
    );
endinterface

// File: rtl/cache_control.sv
// Control FSM for the 2-way write-back cache: hit handling, victim writeback, line allocate,
// plus saturating hit/miss counters.
module cache_control #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic          clk,
    input  logic          reset,
    cache_control_if.slave bus
);

    typedef enum logic [1:0] {
        COMPARE,
        WRITEBACK,
        ALLOCATE
    } state_e;

    state_e               state_q, state_d;
    logic                 victim_q, victim_d;
    logic                 miss_flag_q, miss_flag_d;
    logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

    logic        req_c;
    logic        is_write_c;
    logic        vic_c;
    logic        vic_dirty_c;
    logic        mem_resp_c;
    logic        pmem_read_c;
    logic        pmem_write_c;
    logic        data0_wl_c, data1_wl_c;
    logic        tag0_w_c, tag1_w_c;
    logic        valid0_w_c, valid1_w_c;
    logic        dirty0_w_c, dirty1_w_c;
    logic        valid_in_c, dirty_in_c;
    logic        update_lru_c;
    logic        wb_sel_c;
    logic [1:0]  adrmux_sel_c;
    logic [15:0] offset_sel_c;

    assign req_c       = bus.mem_read | bus.mem_write;
    assign is_write_c  = bus.mem_write;
    // LRU_out = 1 names way0 as least recently used, so the victim index is its inverse.
    assign vic_c       = ~bus.LRU_out;
    assign vic_dirty_c = vic_c ? (bus.valid1_out & bus.dirty1_out)
                               : (bus.valid0_out & bus.dirty0_out);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= COMPARE;
            victim_q    <= 1'b0;
            miss_flag_q <= 1'b0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            victim_q    <= victim_d;
            miss_flag_q <= miss_flag_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Next state and strobes; outputs stay quiet while reset is held.
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        miss_flag_d  = miss_flag_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        mem_resp_c   = 1'b0;
        pmem_read_c  = 1'b0;
        pmem_write_c = 1'b0;
        data0_wl_c   = 1'b0;
        data1_wl_c   = 1'b0;
        tag0_w_c     = 1'b0;
        tag1_w_c     = 1'b0;
        valid0_w_c   = 1'b0;
        valid1_w_c   = 1'b0;
        dirty0_w_c   = 1'b0;
        dirty1_w_c   = 1'b0;
        valid_in_c   = 1'b0;
        dirty_in_c   = 1'b0;
        update_lru_c = 1'b0;
        wb_sel_c     = 1'b0;
        adrmux_sel_c = 2'd0;
        offset_sel_c = 16'd0;

        if (!reset) begin
            unique case (state_q)
                COMPARE: begin
                    if (req_c) begin
                        if (bus.hit0 | bus.hit1) begin
                            mem_resp_c   = 1'b1;
                            update_lru_c = (bus.hit0 & bus.LRU_out) | (bus.hit1 & ~bus.LRU_out);
                            if (is_write_c) begin
                                data0_wl_c   = bus.hit0;
                                dirty0_w_c   = bus.hit0;
                                data1_wl_c   = ~bus.hit0;
                                dirty1_w_c   = ~bus.hit0;
                                dirty_in_c   = 1'b1;
                                wb_sel_c     = 1'b1;
                                offset_sel_c = 16'(bus.mem_byte_enable) << {bus.mem_offset, 1'b0};
                            end
                            // The re-compare after a fill is not a genuine hit.
                            if (!miss_flag_q && (hit_cnt_q != '1)) begin
                                hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
                            end
                            miss_flag_d = 1'b0;
                        end else begin
                            victim_d    = vic_c;
                            miss_flag_d = 1'b1;
                            if (miss_cnt_q != '1) begin
                                miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
                            end
                            state_d = vic_dirty_c ? WRITEBACK : ALLOCATE;
                        end
                    end
                end
                WRITEBACK: begin
                    pmem_write_c = 1'b1;
                    adrmux_sel_c = 2'd1 + 2'(victim_q);
                    if (bus.pmem_resp) begin
                        state_d = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    pmem_read_c = 1'b1;
                    if (bus.pmem_resp) begin
                        data0_wl_c = ~victim_q;
                        tag0_w_c   = ~victim_q;
                        valid0_w_c = ~victim_q;
                        dirty0_w_c = ~victim_q;
                        data1_wl_c = victim_q;
                        tag1_w_c   = victim_q;
                        valid1_w_c = victim_q;
                        dirty1_w_c = victim_q;
                        valid_in_c = 1'b1;
                        state_d    = COMPARE;
                    end
                end
                default: state_d = COMPARE;
            endcase
        end
    end

    assign bus.mem_resp        = mem_resp_c;
    assign bus.pmem_read       = pmem_read_c;
    assign bus.pmem_write      = pmem_write_c;
    assign bus.data0_writeline = data0_wl_c;
    assign bus.data1_writeline = data1_wl_c;
    assign bus.tag0_write      = tag0_w_c;
    assign bus.tag1_write      = tag1_w_c;
    assign bus.valid0_write    = valid0_w_c;
    assign bus.valid1_write    = valid1_w_c;
    assign bus.dirty0_write    = dirty0_w_c;
    assign bus.dirty1_write    = dirty1_w_c;
    assign bus.valid_in        = valid_in_c;
    assign bus.dirty_in        = dirty_in_c;
    assign bus.updateLRU       = update_lru_c;
    assign bus.wb_sel          = wb_sel_c;
    assign bus.adrmux_sel      = adrmux_sel_c;
    assign bus.offset_sel      = offset_sel_c;
    assign bus.hit_count       = hit_cnt_q;
    assign bus.miss_count      = miss_cnt_q;

endmodule

// File: tb/tb_cache_control.sv
// Scoreboard bench for cache_control: stimulus queues expected output cycles, a negedge monitor
// pops and compares every cycle in which the controller drives anything.
module tb_cache_control;

    localparam int unsigned CW = 4;

    typedef struct packed {
        logic          mem_resp;
        logic          pmem_read;
        logic          pmem_write;
        logic          d0, d1, t0, t1, v0, v1, dt0, dt1;
        logic          valid_in;
        logic          dirty_in;
        logic          upd;
        logic          wb_sel;
        logic [1:0]    adr;
        logic [15:0]   off;
        logic [CW-1:0] hc;
        logic [CW-1:0] mc;
    } rec_t;

    logic clk = 1'b0;
    logic reset;

    cache_control_if #(.CNT_WIDTH(CW)) bus ();
    cache_control #(.CNT_WIDTH(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    rec_t        q[$];
    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    int unsigned n_hits = 0;
    int unsigned n_miss = 0;
    rec_t        mon_a, mon_e;

    function automatic rec_t sample();
        rec_t r;
        r.mem_resp   = bus.mem_resp;
        r.pmem_read  = bus.pmem_read;
        r.pmem_write = bus.pmem_write;
        r.d0         = bus.data0_writeline;
        r.d1         = bus.data1_writeline;
        r.t0         = bus.tag0_write;
        r.t1         = bus.tag1_write;
        r.v0         = bus.valid0_write;
        r.v1         = bus.valid1_write;
        r.dt0        = bus.dirty0_write;
        r.dt1        = bus.dirty1_write;
        r.valid_in   = bus.valid_in;
        r.dirty_in   = bus.dirty_in;
        r.upd        = bus.updateLRU;
        r.wb_sel     = bus.wb_sel;
        r.adr        = bus.adrmux_sel;
        r.off        = bus.offset_sel;
        r.hc         = bus.hit_count;
        r.mc         = bus.miss_count;
        return r;
    endfunction

    function automatic bit active(rec_t r);
        rec_t t = r;
        t.hc = '0;
        t.mc = '0;
        return |t;
    endfunction

    // Counter value seen after n events: clipped at the all-ones value.
    function automatic logic [CW-1:0] sat(int unsigned n);
        int unsigned top = (1 << CW) - 1;
        return (n >= top) ? {CW{1'b1}} : CW'(n);
    endfunction

    function automatic rec_t hit_rec(bit h0, bit h1, bit we, logic [2:0] off, logic [1:0] be, bit lru);
        rec_t r = '0;
        r.mem_resp = 1'b1;
        r.upd      = (h0 & lru) | (h1 & !lru);
        if (we) begin
            r.dirty_in = 1'b1;
            r.wb_sel   = 1'b1;
            r.off[int'(off)*2 +: 2] = be;
            if (h0) begin r.d0 = 1'b1; r.dt0 = 1'b1; end
            else    begin r.d1 = 1'b1; r.dt1 = 1'b1; end
        end
        r.hc = sat(n_hits);
        r.mc = sat(n_miss);
        return r;
    endfunction

    task automatic push_cnt(input rec_t r_in);
        rec_t r = r_in;
        r.hc = sat(n_hits);
        r.mc = sat(n_miss);
        q.push_back(r);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // One CPU request from issue to completion; expected output cycles are queued as they are driven.
    task automatic txn(input bit miss, input bit h0, input bit h1, input bit we, input bit rd_too,
                       input logic [2:0] off, input logic [1:0] be, input bit lru,
                       input logic [1:0] vv, input logic [1:0] dd, input int wl, input int rl);
        rec_t r;
        bit   v;
        bus.mem_read        = !we | rd_too;
        bus.mem_write       = we;
        bus.mem_offset      = off;
        bus.mem_byte_enable = be;
        bus.LRU_out         = lru;
        bus.valid0_out      = vv[0];
        bus.valid1_out      = vv[1];
        bus.dirty0_out      = dd[0];
        bus.dirty1_out      = dd[1];
        bus.pmem_resp       = 1'($urandom_range(0, 1));
        if (!miss) begin
            bus.hit0 = h0;
            bus.hit1 = h1;
            q.push_back(hit_rec(h0, h1, we, off, be, lru));
            n_hits++;
            @(posedge clk); #1;
        end else begin
            bus.hit0 = 1'b0;
            bus.hit1 = 1'b0;
            v = !lru;
            n_miss++;
            if (vv[v] && dd[v]) begin
                for (int i = 0; i < wl; i++) begin
                    @(posedge clk); #1;
                    bus.pmem_resp = (i == wl - 1);
                    r = '0;
                    r.pmem_write = 1'b1;
                    r.adr = v ? 2'd2 : 2'd1;
                    push_cnt(r);
                end
            end
            for (int i = 0; i < rl; i++) begin
                @(posedge clk); #1;
                bus.pmem_resp = (i == rl - 1);
                r = '0;
                r.pmem_read = 1'b1;
                if (i == rl - 1) begin
                    if (v) begin r.d1 = 1'b1; r.t1 = 1'b1; r.v1 = 1'b1; r.dt1 = 1'b1; end
                    else   begin r.d0 = 1'b1; r.t0 = 1'b1; r.v0 = 1'b1; r.dt0 = 1'b1; end
                    r.valid_in = 1'b1;
                end
                push_cnt(r);
            end
            @(posedge clk); #1;
            bus.pmem_resp = 1'b0;
            bus.hit0 = !v;
            bus.hit1 = v;
            q.push_back(hit_rec(!v, v, we, off, be, lru));
            @(posedge clk); #1;
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.hit0      = 1'b0;
        bus.hit1      = 1'b0;
        bus.pmem_resp = 1'b0;
        chk("queue_drained", 64'(q.size()), 64'd0);
        q.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.pmem_resp = 1'($urandom_range(0, 1));
            bus.hit0      = 1'($urandom_range(0, 1));
            bus.hit1      = 1'($urandom_range(0, 1));
            bus.LRU_out   = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        bus.pmem_resp = 1'b0;
        bus.hit0      = 1'b0;
        bus.hit1      = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_a = sample();
            if (active(mon_a)) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output act=%h exp=idle", mon_a);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_a !== mon_e) begin
                        errors++;
                        $display("FAIL output_cycle act=%h exp=%h", mon_a, mon_e);
                    end
                end
            end
        end
    end

    initial begin
        rec_t zero = '0;
        bit   ms, h0, h1;
        reset               = 1'b1;
        bus.mem_read        = 1'b1;
        bus.mem_write       = 1'b1;
        bus.mem_offset      = 3'd3;
        bus.mem_byte_enable = 2'b11;
        bus.hit0            = 1'b1;
        bus.hit1            = 1'b0;
        bus.valid0_out      = 1'b1;
        bus.valid1_out      = 1'b1;
        bus.dirty0_out      = 1'b1;
        bus.dirty1_out      = 1'b1;
        bus.LRU_out         = 1'b1;
        bus.pmem_resp       = 1'b1;
        #1;
        chk("reset_outputs", 64'(sample()), 64'(zero));
        @(posedge clk); #1;
        chk("reset_outputs_edge", 64'(sample()), 64'(zero));
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.hit0      = 1'b0;
        bus.pmem_resp = 1'b0;
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Directed: read hit, write hit, clean miss, dirty miss, write miss with read also high.
        txn(0, 1, 0, 0, 0, 3'd0, 2'b00, 1, 2'b11, 2'b00, 1, 1);
        txn(0, 0, 1, 1, 0, 3'd5, 2'b10, 0, 2'b11, 2'b00, 1, 1);
        txn(1, 0, 0, 0, 0, 3'd2, 2'b01, 0, 2'b01, 2'b11, 1, 4);
        txn(1, 0, 0, 0, 0, 3'd1, 2'b11, 1, 2'b11, 2'b01, 3, 2);
        txn(1, 0, 0, 1, 1, 3'd7, 2'b11, 0, 2'b11, 2'b10, 2, 3);
        idle(2);

        for (int k = 0; k < 150; k++) begin
            ms = ($urandom_range(0, 9) < 4);
            h0 = 1'($urandom_range(0, 1));
            h1 = !h0 | ($urandom_range(0, 9) == 0);
            txn(ms, h0, h1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                $urandom_range(1, 4), $urandom_range(1, 4));
            idle($urandom_range(0, 2));
        end

        // Reset in the middle of a line fill.
        mon_en = 1'b0;
        bus.mem_read   = 1'b1;
        bus.LRU_out    = 1'b0;
        bus.valid0_out = 1'b0;
        bus.valid1_out = 1'b0;
        bus.pmem_resp  = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("alloc_pmem_read", 64'(bus.pmem_read), 64'd1);
        chk("alloc_miss_count", 64'(bus.miss_count), 64'(sat(n_miss + 1)));
        #2 reset = 1'b1;
        #1;
        chk("mid_reset_pmem_read", 64'(bus.pmem_read), 64'd0);
        chk("mid_reset_outputs", 64'(sample()), 64'(zero));
        bus.pmem_resp = 1'b1;
        @(posedge clk); #1;
        chk("mid_reset_no_fill", 64'(sample()), 64'(zero));
        bus.mem_read  = 1'b0;
        bus.pmem_resp = 1'b0;
        reset         = 1'b0;
        n_hits        = 0;
        n_miss        = 0;
        q.delete();
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Twenty read hits after reset: counter must clip at all-ones.
        for (int k = 0; k < 20; k++) begin
            h0 = 1'($urandom_range(0, 1));
            txn(0, h0, !h0, 0, 0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 2'b11, 2'b00, 1, 1);
        end
        chk("hit_count_saturated", 64'(bus.hit_count), 64'(4'hF));
        chk("miss_count_after_reset", 64'(bus.miss_count), 64'd0);
        idle(3);
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
